// File: rtl/capture_readout_1260.sv
// capture_readout_1260: reads capture-memory entries one at a time and streams each
// entry out as OUT_W-bit words, last word zero-extended, with entry/last markers.
module capture_readout_1260 #(
    parameter int DATA_W = 1260,
    parameter int ADDR_W = 9,
    parameter int OUT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_addr,
    input  logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              done,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_dout,
    output logic [OUT_W-1:0]  m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_eoe,
    output logic              m_last
);
    localparam int WPE = (DATA_W + OUT_W - 1) / OUT_W;
    localparam int BW  = WPE * OUT_W;
    localparam int IW  = WPE > 1 ? $clog2(WPE) : 1;

    typedef enum logic [2:0] {IDLE, RD, CAP, SEND, FIN} state_t;

    state_t            state, nxt;
    logic [ADDR_W:0]   rem;
    logic [IW-1:0]     widx;
    logic [BW-1:0]     sbuf, ext;
    logic              zpend;
    logic              hs, last_word, eoe_hs, more, rem_one;
    logic              mem_en_d, busy_d, done_d, m_valid_d;

    assign ext       = BW'(mem_dout);
    assign hs        = state == SEND && m_valid && m_ready;
    assign last_word = widx == IW'(WPE - 1);
    assign eoe_hs    = hs && last_word;
    assign rem_one   = rem == {{ADDR_W{1'b0}}, 1'b1};
    assign more      = rem > {{ADDR_W{1'b0}}, 1'b1};

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= nxt;
    end

    // A zero-length request spends one extra FIN cycle so done lands two cycles after start.
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = start ? (count != '0 ? RD : FIN) : IDLE;
            RD:      nxt = CAP;
            CAP:     nxt = SEND;
            SEND:    nxt = eoe_hs ? (more ? RD : FIN) : SEND;
            FIN:     nxt = zpend ? FIN : IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_en_d  = nxt == RD;
        busy_d    = nxt != IDLE;
        done_d    = nxt == FIN && state != IDLE;
        m_valid_d = nxt == SEND;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            mem_en   <= 1'b0;
            mem_addr <= '0;
            m_valid  <= 1'b0;
            m_data   <= '0;
            m_eoe    <= 1'b0;
            m_last   <= 1'b0;
            widx     <= '0;
            rem      <= '0;
            sbuf     <= '0;
            zpend    <= 1'b0;
        end else begin
            busy    <= busy_d;
            done    <= done_d;
            mem_en  <= mem_en_d;
            m_valid <= m_valid_d;
            zpend   <= state == IDLE && start && count == '0;
            if (state == IDLE && start) begin
                mem_addr <= first_addr;
                rem      <= count;
            end
            if (state == CAP) begin
                m_data <= ext[OUT_W-1:0];
                sbuf   <= ext >> OUT_W;
                widx   <= '0;
                m_eoe  <= WPE == 1;
                m_last <= WPE == 1 && rem_one;
            end
            if (hs && !last_word) begin
                m_data <= sbuf[OUT_W-1:0];
                sbuf   <= sbuf >> OUT_W;
                widx   <= widx + 1'b1;
                m_eoe  <= (widx + 1'b1) == IW'(WPE - 1);
                m_last <= (widx + 1'b1) == IW'(WPE - 1) && rem_one;
            end
            if (eoe_hs) begin
                mem_addr <= mem_addr + 1'b1;
                rem      <= rem - 1'b1;
                m_eoe    <= 1'b0;
                m_last   <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_capture_readout_1260.sv
// tb_capture_readout_1260: directed sequence with random memory contents and random
// backpressure, checked against a word-queue model built from the entry contents.
module tb_capture_readout_1260;
    localparam int DW = 1260;
    localparam int AW = 9;
    localparam int OW = 32;
    localparam int WPE = 40;

    typedef struct {
        logic [OW-1:0] d;
        logic          eoe;
        logic          last;
    } wexp_t;

    logic          clk = 0;
    logic          rst = 1;
    logic          start = 0;
    logic [AW-1:0] first_addr = 0;
    logic [AW:0]   count = 0;
    logic          busy, done, mem_en, m_valid, m_eoe, m_last;
    logic          m_ready = 1;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_dout = '0;
    logic [OW-1:0] m_data;

    logic [DW-1:0] mem [512];
    wexp_t         exp_w[$];
    logic [AW-1:0] exp_a[$];

    int errors = 0, checks = 0, cyc = 0;
    int n_words, n_eoe, n_last, n_mem, n_done, n_vcyc, first_mem, first_v, done_cyc, t0;
    logic          rnd_ready = 0;
    logic          stalled = 0;
    logic [OW-1:0] pd;
    logic [1:0]    pf;

    capture_readout_1260 dut (
        .clk(clk), .rst(rst), .start(start), .first_addr(first_addr), .count(count),
        .busy(busy), .done(done), .mem_en(mem_en), .mem_addr(mem_addr), .mem_dout(mem_dout),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_eoe(m_eoe), .m_last(m_last)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (mem_en) mem_dout <= mem[mem_addr];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        #1 m_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    always @(negedge clk) begin
        if (rst) begin
            stalled = 0;
        end else begin
            if (mem_en) begin
                n_mem++;
                if (first_mem < 0) first_mem = cyc;
                if (exp_a.size() == 0) chk("extra_mem_read", 1, 0);
                else chk("mem_addr", 64'(mem_addr), 64'(exp_a.pop_front()));
            end
            if (done) begin
                n_done++;
                done_cyc = cyc;
            end
            if (m_valid) begin
                n_vcyc++;
                if (first_v < 0) first_v = cyc;
            end
            if (stalled) begin
                chk("stall_valid", 64'(m_valid), 1);
                chk("stall_data", 64'(m_data), 64'(pd));
                chk("stall_flags", 64'({m_eoe, m_last}), 64'(pf));
            end
            if (m_valid && m_ready) begin
                wexp_t e;
                n_words++;
                n_eoe += int'(m_eoe);
                n_last += int'(m_last);
                if (exp_w.size() == 0) chk("extra_word", 1, 0);
                else begin
                    e = exp_w.pop_front();
                    if (m_data !== e.d) chk("word_data", 64'(m_data), 64'(e.d));
                    if ({m_eoe, m_last} !== {e.eoe, e.last})
                        chk("word_flags", 64'({m_eoe, m_last}), 64'({e.eoe, e.last}));
                end
            end
            stalled = m_valid && !m_ready;
            pd = m_data;
            pf = {m_eoe, m_last};
        end
    end

    task automatic start_txn(input logic [AW-1:0] fa, input logic [AW:0] cnt);
        logic [DW-1:0] ent;
        logic [AW-1:0] a;
        for (int e = 0; e < int'(cnt); e++) begin
            a = fa + AW'(e);
            exp_a.push_back(a);
            for (int k = 0; k < WPE; k++) begin
                wexp_t w;
                ent = mem[a] >> (OW * k);
                w.d = ent[OW-1:0];
                w.eoe = k == WPE - 1;
                w.last = k == WPE - 1 && e == int'(cnt) - 1;
                exp_w.push_back(w);
            end
        end
        n_words = 0; n_eoe = 0; n_last = 0; n_mem = 0; n_done = 0; n_vcyc = 0;
        first_mem = -1; first_v = -1; done_cyc = -1;
        @(posedge clk);
        #1;
        start = 1; first_addr = fa; count = cnt; t0 = cyc;
        @(posedge clk);
        #1;
        start = 0; first_addr = AW'($urandom); count = (AW + 1)'($urandom);
    endtask

    task automatic wait_done(input int budget);
        int i;
        for (i = 0; i < budget && n_done == 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (n_done == 0) chk("done_timeout", 0, 1);
        repeat (3) @(negedge clk);
        #1;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_busy"}, 64'(busy), 0);
        chk({tag, "_done"}, 64'(done), 0);
        chk({tag, "_mem_en"}, 64'(mem_en), 0);
        chk({tag, "_mem_addr"}, 64'(mem_addr), 0);
        chk({tag, "_m_valid"}, 64'(m_valid), 0);
        chk({tag, "_m_data"}, 64'(m_data), 0);
        chk({tag, "_flags"}, 64'({m_eoe, m_last}), 0);
    endtask

    initial begin
        logic [1279:0] tmp;
        for (int a = 0; a < 512; a++) begin
            for (int k = 0; k < WPE; k++) tmp[32*k +: 32] = $urandom;
            mem[a] = tmp[DW-1:0];
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_idle_outputs("reset");
        #1 rst = 0;

        // single entry, latency profile
        start_txn(9'd5, 10'd1);
        wait_done(200);
        chk("t1_mem_en_cyc", 64'(first_mem), 64'(t0 + 1));
        chk("t1_first_valid", 64'(first_v), 64'(t0 + 3));
        chk("t1_done_cyc", 64'(done_cyc), 64'(t0 + 43));
        chk("t1_words", 64'(n_words), 40);
        chk("t1_last", 64'(n_last), 1);
        chk("t1_eoe", 64'(n_eoe), 1);
        chk("t1_left", 64'(exp_w.size() + exp_a.size()), 0);

        // address wrap across the top of memory
        start_txn(9'd510, 10'd4);
        wait_done(500);
        chk("t2_reads", 64'(n_mem), 4);
        chk("t2_words", 64'(n_words), 160);
        chk("t2_eoe", 64'(n_eoe), 4);
        chk("t2_last", 64'(n_last), 1);
        chk("t2_done_cyc", 64'(done_cyc), 64'(t0 + 169));
        chk("t2_valid_cycles", 64'(n_vcyc), 160);
        chk("t2_left", 64'(exp_w.size() + exp_a.size()), 0);

        // random backpressure
        rnd_ready = 1;
        start_txn(AW'($urandom), 10'd3);
        wait_done(3000);
        rnd_ready = 0;
        chk("t3_words", 64'(n_words), 120);
        chk("t3_last", 64'(n_last), 1);
        chk("t3_done_count", 64'(n_done), 1);
        chk("t3_left", 64'(exp_w.size() + exp_a.size()), 0);

        // zero-length request
        start_txn(9'd77, 10'd0);
        wait_done(50);
        chk("t4_done_cyc", 64'(done_cyc), 64'(t0 + 2));
        chk("t4_reads", 64'(n_mem), 0);
        chk("t4_valid", 64'(n_vcyc), 0);
        chk("t4_busy_after", 64'(busy), 0);

        // start pulse while streaming must be ignored
        start_txn(9'd100, 10'd2);
        while (n_words < 10) begin
            @(negedge clk);
            #1;
        end
        start = 1; first_addr = 9'd300; count = 10'd5;
        @(posedge clk);
        #1 start = 0;
        wait_done(500);
        repeat (10) @(negedge clk);
        #1;
        chk("t5_words", 64'(n_words), 80);
        chk("t5_reads", 64'(n_mem), 2);
        chk("t5_done_count", 64'(n_done), 1);
        chk("t5_busy_after", 64'(busy), 0);
        chk("t5_left", 64'(exp_w.size() + exp_a.size()), 0);

        // reset in the middle of an entry, start during reset ignored
        start_txn(AW'($urandom), 10'd2);
        for (int i = 0; i < 200 && n_words < 17; i++) begin
            @(negedge clk);
            #1;
        end
        chk("t6_reached_word17", 64'(n_words), 17);
        rst = 1;
        @(negedge clk);
        chk_idle_outputs("t6_abort");
        #1;
        start = 1; count = 10'd1; first_addr = 9'd9;
        @(negedge clk);
        chk("t6_start_in_rst", 64'(busy), 0);
        #1;
        rst = 0; start = 0;
        exp_w.delete();
        exp_a.delete();
        n_done = 0;
        repeat (50) @(negedge clk);
        #1;
        chk("t6_no_done", 64'(n_done), 0);
        chk("t6_idle", 64'(busy), 0);
        start_txn(9'd511, 10'd1);
        wait_done(200);
        chk("t6_recover_words", 64'(n_words), 40);
        chk("t6_recover_last", 64'(n_last), 1);
        chk("t6_recover_done", 64'(done_cyc), 64'(t0 + 43));
        chk("t6_left", 64'(exp_w.size() + exp_a.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
